// File: rtl/debug_unit.sv
// debug_unit
//   Command processor sitting between the host UART byte interface and the
//   mips core. It decodes single-byte host commands, loads programs into
//   instruction memory, controls run mode (continuous / step / halted) and
//   streams pipeline latches and the register file back to the host. Every
//   completed command is acknowledged with the byte 'R' (0x52).
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_rx_data/valid     received host byte, valid for one cycle
//   o_tx_data/start     byte to transmit, one-cycle start pulse
//   i_tx_done           transmitter finished the current byte
//   o_imem_we/addr/data instruction memory write port
//   o_cpu_rst           holds the core in reset during a program load
//   o_stall             1 = pipeline frozen
//   o_reg_addr          register file read address
//   i_reg_data          register file read data (combinational)
//   i_if_id .. i_mem_wb pipeline latch contents for dumping
module debug_unit #(
  parameter int SIZE            = 32,
  parameter int IF_ID_SIZE      = 64,
  parameter int ID_EX_SIZE      = 129,
  parameter int EX_MEM_SIZE     = 78,
  parameter int MEM_WB_SIZE     = 72,
  parameter int NUM_REGISTERS   = 32,
  parameter int MAX_INSTRUCTION = 64,
  parameter int ADDR_WIDTH      = $clog2(MAX_INSTRUCTION)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_imem_we,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  output logic [SIZE-1:0]        o_imem_data,
  output logic                   o_cpu_rst,
  output logic                   o_stall,
  output logic [4:0]             o_reg_addr,
  input  logic [SIZE-1:0]        i_reg_data,
  input  logic [IF_ID_SIZE-1:0]  i_if_id,
  input  logic [ID_EX_SIZE-1:0]  i_id_ex,
  input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0] i_mem_wb
);

  localparam logic [7:0] CMD_CONT  = 8'h08;
  localparam logic [7:0] CMD_STEPM = 8'h11;
  localparam logic [7:0] CMD_RUN   = 8'h0D;
  localparam logic [7:0] CMD_HALT  = 8'h0B;
  localparam logic [7:0] CMD_STEP  = 8'h0A;
  localparam logic [7:0] CMD_LOAD  = 8'h07;
  localparam logic [7:0] CMD_REGS  = 8'h01;
  localparam logic [7:0] CMD_IF_ID = 8'h02;
  localparam logic [7:0] CMD_ID_EX = 8'h03;
  localparam logic [7:0] CMD_EX_MEM = 8'h04;
  localparam logic [7:0] CMD_MEM_WB = 8'h05;
  localparam logic [7:0] ACK_BYTE  = 8'h52;

  localparam int IF_ID_BYTES  = (IF_ID_SIZE + 7) / 8;
  localparam int ID_EX_BYTES  = (ID_EX_SIZE + 7) / 8;
  localparam int EX_MEM_BYTES = (EX_MEM_SIZE + 7) / 8;
  localparam int MEM_WB_BYTES = (MEM_WB_SIZE + 7) / 8;
  localparam int MAX_A        = (IF_ID_BYTES > ID_EX_BYTES) ? IF_ID_BYTES : ID_EX_BYTES;
  localparam int MAX_B        = (EX_MEM_BYTES > MEM_WB_BYTES) ? EX_MEM_BYTES : MEM_WB_BYTES;
  localparam int SNAP_BYTES   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int SNAP_BITS    = SNAP_BYTES * 8;
  localparam int REG_BYTES    = NUM_REGISTERS * 4;
  localparam int MAX_DUMP     = (REG_BYTES > SNAP_BYTES) ? REG_BYTES : SNAP_BYTES;
  localparam int LEFT_W       = $clog2(MAX_DUMP + 1);
  localparam int CNT_W        = $clog2(MAX_INSTRUCTION + 1);

  typedef enum logic [2:0] {
    IDLE, LD_CNT, LD_WORD, LD_HALT, DUMP_BYTE, DUMP_WAIT, ACK, ACK_WAIT
  } state_t;

  state_t state_q, state_d;

  logic                 step_mode;
  logic                 run;
  logic                 step_pulse;
  logic                 dump_regs;
  logic [1:0]           reg_byte;
  logic [SNAP_BITS-1:0] snap;
  logic [LEFT_W-1:0]    dump_left;
  logic [SIZE-1:0]      shift_q;
  logic [1:0]           byte_cnt;
  logic [CNT_W-1:0]     word_idx;
  logic [CNT_W-1:0]     word_cnt;

  logic [CNT_W-1:0]     cnt_clamped;
  logic                 last_word;
  logic                 halt_fits;
  logic [7:0]           reg_byte_val;

  // The pipeline only advances when running in continuous mode, or for the
  // single cycle granted by a step command.
  assign o_stall = ~(run & ~step_mode) & ~step_pulse;

  assign cnt_clamped  = (int'(i_rx_data) > MAX_INSTRUCTION) ? CNT_W'(MAX_INSTRUCTION)
                                                            : CNT_W'(i_rx_data);
  assign last_word    = (word_idx + CNT_W'(1)) == word_cnt;
  // A full memory leaves no address for the zero halt marker, so it is skipped.
  assign halt_fits    = word_cnt < CNT_W'(MAX_INSTRUCTION);
  assign reg_byte_val = i_reg_data[{reg_byte, 3'b000} +: 8];

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; unknown command bytes leave the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_CONT, CMD_STEPM, CMD_RUN, CMD_HALT, CMD_STEP: state_d = ACK;
            CMD_LOAD: state_d = LD_CNT;
            CMD_REGS, CMD_IF_ID, CMD_ID_EX, CMD_EX_MEM, CMD_MEM_WB: state_d = DUMP_BYTE;
            default: state_d = IDLE;
          endcase
        end
      end
      LD_CNT: if (i_rx_valid) state_d = (i_rx_data == 8'd0) ? ACK : LD_WORD;
      LD_WORD: begin
        if (i_rx_valid && byte_cnt == 2'd3 && last_word)
          state_d = halt_fits ? LD_HALT : ACK;
      end
      LD_HALT:   state_d = ACK;
      DUMP_BYTE: state_d = DUMP_WAIT;
      DUMP_WAIT: if (i_tx_done) state_d = (dump_left == LEFT_W'(1)) ? ACK : DUMP_BYTE;
      ACK:       state_d = ACK_WAIT;
      ACK_WAIT:  if (i_tx_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: run control, program loading, dump sequencing and TX bytes.
  // Latch dumps shift a zero-extended snapshot right one byte per transmitted
  // byte, so the unused high bits of the last byte naturally go out as zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_mode   <= 1'b0;
      run         <= 1'b0;
      step_pulse  <= 1'b0;
      dump_regs   <= 1'b0;
      reg_byte    <= '0;
      snap        <= '0;
      dump_left   <= '0;
      shift_q     <= '0;
      byte_cnt    <= '0;
      word_idx    <= '0;
      word_cnt    <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_imem_we   <= 1'b0;
      o_imem_addr <= '0;
      o_imem_data <= '0;
      o_cpu_rst   <= 1'b0;
      o_reg_addr  <= '0;
    end else begin
      o_tx_start <= 1'b0;
      o_imem_we  <= 1'b0;
      step_pulse <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_CONT:  step_mode <= 1'b0;
              CMD_STEPM: begin
                step_mode <= 1'b1;
                run       <= 1'b0;
              end
              CMD_RUN:   run <= 1'b1;
              CMD_HALT:  run <= 1'b0;
              CMD_STEP:  step_pulse <= step_mode & run;
              CMD_LOAD: begin
                o_cpu_rst <= 1'b1;
                run       <= 1'b0;
              end
              CMD_REGS: begin
                dump_regs  <= 1'b1;
                o_reg_addr <= '0;
                reg_byte   <= '0;
                dump_left  <= LEFT_W'(REG_BYTES);
              end
              CMD_IF_ID: begin
                dump_regs <= 1'b0;
                snap      <= SNAP_BITS'(i_if_id);
                dump_left <= LEFT_W'(IF_ID_BYTES);
              end
              CMD_ID_EX: begin
                dump_regs <= 1'b0;
                snap      <= SNAP_BITS'(i_id_ex);
                dump_left <= LEFT_W'(ID_EX_BYTES);
              end
              CMD_EX_MEM: begin
                dump_regs <= 1'b0;
                snap      <= SNAP_BITS'(i_ex_mem);
                dump_left <= LEFT_W'(EX_MEM_BYTES);
              end
              CMD_MEM_WB: begin
                dump_regs <= 1'b0;
                snap      <= SNAP_BITS'(i_mem_wb);
                dump_left <= LEFT_W'(MEM_WB_BYTES);
              end
              default: ;
            endcase
          end
        end
        LD_CNT: begin
          if (i_rx_valid) begin
            word_cnt <= cnt_clamped;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        LD_WORD: begin
          if (i_rx_valid) begin
            shift_q  <= {i_rx_data, shift_q[SIZE-1:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_imem_we   <= 1'b1;
              o_imem_addr <= ADDR_WIDTH'(word_idx);
              o_imem_data <= {i_rx_data, shift_q[SIZE-1:8]};
              word_idx    <= word_idx + CNT_W'(1);
            end
          end
        end
        LD_HALT: begin
          o_imem_we   <= 1'b1;
          o_imem_addr <= ADDR_WIDTH'(word_cnt);
          o_imem_data <= '0;
        end
        DUMP_BYTE: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= dump_regs ? reg_byte_val : snap[7:0];
        end
        DUMP_WAIT: begin
          if (i_tx_done) begin
            dump_left <= dump_left - LEFT_W'(1);
            if (dump_regs) begin
              reg_byte <= reg_byte + 2'd1;
              if (reg_byte == 2'd3) o_reg_addr <= o_reg_addr + 5'd1;
            end else begin
              snap <= snap >> 8;
            end
          end
        end
        ACK: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= ACK_BYTE;
          o_cpu_rst  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit
//   Self-checking bench for debug_unit. A host driver sends command bytes
//   with random gaps, a transmitter model answers each start pulse with a
//   done pulse after a random delay, and a behavioural model predicts the
//   response bytes, instruction memory writes and the stall / core-reset
//   levels from the command semantics.
module tb_debug_unit;

  localparam int SIZE = 32;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [7:0]   i_rx_data = '0;
  logic         i_rx_valid = 1'b0;
  logic [7:0]   o_tx_data;
  logic         o_tx_start;
  logic         i_tx_done = 1'b0;
  logic         o_imem_we;
  logic [5:0]   o_imem_addr;
  logic [31:0]  o_imem_data;
  logic         o_cpu_rst;
  logic         o_stall;
  logic [4:0]   o_reg_addr;
  logic [31:0]  i_reg_data;
  logic [63:0]  i_if_id = '0;
  logic [128:0] i_id_ex = '0;
  logic [77:0]  i_ex_mem = '0;
  logic [71:0]  i_mem_wb = '0;

  logic [31:0]  regs [32];
  assign i_reg_data = regs[o_reg_addr];

  int checks = 0;
  int errors = 0;

  logic [7:0]   txq [$];
  logic [37:0]  wrq [$];
  logic [31:0]  load_words [$];
  bit           tx_busy = 1'b0;

  bit           m_run = 1'b0;
  bit           m_step_mode = 1'b0;
  bit           m_step_now = 1'b0;
  int           exp_cpu_rst = 0;
  int           stall_low = 0;

  debug_unit dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_cpu_rst(o_cpu_rst), .o_stall(o_stall),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .i_if_id(i_if_id), .i_id_ex(i_id_ex), .i_ex_mem(i_ex_mem), .i_mem_wb(i_mem_wb)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drives one host byte after a random idle gap; it is accepted on the
  // rising edge just before this task returns.
  task automatic applyStimulus(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(posedge i_clk);
    #1;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic randomizeLatches();
    i_if_id  = {$urandom, $urandom};
    i_id_ex  = 129'({$urandom, $urandom, $urandom, $urandom, $urandom});
    i_ex_mem = 78'({$urandom, $urandom, $urandom});
    i_mem_wb = 72'({$urandom, $urandom, $urandom});
  endtask

  // Per-cycle comparison of the level outputs against the model, plus
  // capture of instruction memory writes.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_stall === 1'b0) stall_low++;
      checkOutput("o_stall", 64'(o_stall), 64'(!(m_run && !m_step_mode) && !m_step_now));
      if (exp_cpu_rst >= 0) checkOutput("o_cpu_rst", 64'(o_cpu_rst), 64'(exp_cpu_rst[0]));
      if (o_imem_we === 1'b1) wrq.push_back({o_imem_addr, o_imem_data});
    end
  end

  // Transmitter model: captures each started byte, checks it is held and
  // not restarted while busy, then returns done after a random delay.
  initial begin
    logic [7:0] held;
    int delay;
    held  = '0;
    delay = 0;
    forever begin
      @(negedge i_clk);
      i_tx_done = 1'b0;
      if (tx_busy) begin
        checkOutput("tx_hold", 64'(o_tx_data), 64'(held));
        checkOutput("tx_start_busy", 64'(o_tx_start), 64'd0);
        if (delay == 0) begin
          i_tx_done = 1'b1;
          tx_busy   = 1'b0;
        end else begin
          delay--;
        end
      end else if (o_tx_start === 1'b1) begin
        held    = o_tx_data;
        txq.push_back(held);
        tx_busy = 1'b1;
        delay   = $urandom_range(0, 3);
      end
    end
  end

  task automatic waitTx(input int n);
    int budget;
    budget = 4000;
    while (txq.size() < n && budget > 0) begin
      @(posedge i_clk);
      budget--;
    end
    if (txq.size() < n) checkOutput("tx_timeout", 64'(txq.size()), 64'(n));
    budget = 20;
    while (tx_busy && budget > 0) begin
      @(posedge i_clk);
      budget--;
    end
    repeat (8) @(posedge i_clk);
    #1;
  endtask

  // Issues one command (with payload for LOAD), predicts its response from
  // the command semantics and compares bytes and memory writes.
  task automatic doCommand(input logic [7:0] cmd, input logic [7:0] cnt, input bit inject);
    logic [7:0]   exp_tx [$];
    logic [37:0]  exp_wr [$];
    logic [135:0] v;
    logic [31:0]  w;
    int           nb;
    int           n;
    int           budget;
    txq.delete();
    wrq.delete();
    v  = '0;
    nb = 0;
    case (cmd)
      8'h07: begin
        applyStimulus(cmd);
        m_run       = 1'b0;
        exp_cpu_rst = 1;
        n = (int'(cnt) > 64) ? 64 : int'(cnt);
        applyStimulus(cnt);
        for (int i = 0; i < n; i++) begin
          w = (load_words.size() > i) ? load_words[i] : $urandom;
          for (int b = 0; b < 4; b++) applyStimulus(w[8*b +: 8]);
          exp_wr.push_back({6'(i), w});
        end
        exp_cpu_rst = -1;
        if (n > 0 && n < 64) exp_wr.push_back({6'(n), 32'h0});
      end
      8'h01: begin
        applyStimulus(cmd);
        for (int r = 0; r < 32; r++)
          for (int b = 0; b < 4; b++) exp_tx.push_back(regs[r][8*b +: 8]);
      end
      8'h02, 8'h03, 8'h04, 8'h05: begin
        case (cmd)
          8'h02:   begin v = 136'(i_if_id);  nb = 8;  end
          8'h03:   begin v = 136'(i_id_ex);  nb = 17; end
          8'h04:   begin v = 136'(i_ex_mem); nb = 10; end
          default: begin v = 136'(i_mem_wb); nb = 9;  end
        endcase
        applyStimulus(cmd);
        randomizeLatches();
        for (int k = 0; k < nb; k++) exp_tx.push_back(v[8*k +: 8]);
      end
      8'h08: begin applyStimulus(cmd); m_step_mode = 1'b0; end
      8'h11: begin applyStimulus(cmd); m_step_mode = 1'b1; m_run = 1'b0; end
      8'h0D: begin applyStimulus(cmd); m_run = 1'b1; end
      8'h0B: begin applyStimulus(cmd); m_run = 1'b0; end
      8'h0A: begin
        applyStimulus(cmd);
        if (m_step_mode && m_run) begin
          m_step_now = 1'b1;
          @(posedge i_clk);
          #1;
          m_step_now = 1'b0;
        end
      end
      default: applyStimulus(cmd);
    endcase
    if (cmd inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08, 8'h0A, 8'h0B, 8'h0D, 8'h11})
      exp_tx.push_back(8'h52);
    if (inject) begin
      budget = 200;
      while (txq.size() < 1 && budget > 0) begin
        @(posedge i_clk);
        budget--;
      end
      @(posedge i_clk);
      #1;
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h0D;
      @(posedge i_clk);
      #1;
      i_rx_valid = 1'b0;
    end
    waitTx(exp_tx.size());
    exp_cpu_rst = 0;
    checkOutput("tx_count", 64'(txq.size()), 64'(exp_tx.size()));
    for (int i = 0; i < txq.size() && i < exp_tx.size(); i++)
      checkOutput("tx_byte", 64'(txq[i]), 64'(exp_tx[i]));
    checkOutput("wr_count", 64'(wrq.size()), 64'(exp_wr.size()));
    for (int i = 0; i < wrq.size() && i < exp_wr.size(); i++)
      checkOutput("imem_write", 64'(wrq[i]), 64'(exp_wr[i]));
  endtask

  initial begin
    logic [7:0] cmds [13];
    logic [7:0] idex_exp [17];
    logic [7:0] c;
    logic [7:0] cnt;
    cmds     = '{8'h08, 8'h11, 8'h0D, 8'h0B, 8'h0A, 8'h07, 8'h01,
                 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF, 8'h00};
    idex_exp = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE,
                 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h01};
    for (int r = 0; r < 32; r++) regs[r] = $urandom;

    // Reset values.
    @(negedge i_clk);
    checkOutput("rst_stall", 64'(o_stall), 64'd1);
    checkOutput("rst_cpu_rst", 64'(o_cpu_rst), 64'd0);
    checkOutput("rst_tx_start", 64'(o_tx_start), 64'd0);
    checkOutput("rst_tx_data", 64'(o_tx_data), 64'd0);
    checkOutput("rst_imem_we", 64'(o_imem_we), 64'd0);
    checkOutput("rst_imem_addr", 64'(o_imem_addr), 64'd0);
    checkOutput("rst_imem_data", 64'(o_imem_data), 64'd0);
    checkOutput("rst_reg_addr", 64'(o_reg_addr), 64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    doCommand(8'h08, 8'h00, 1'b0);
    checkOutput("cont_ack_count", 64'(txq.size()), 64'd1);
    checkOutput("cont_ack_byte", 64'(txq[0]), 64'h52);

    // Directed two-word load.
    load_words = '{32'h3C010001, 32'h3C030003};
    doCommand(8'h07, 8'h02, 1'b0);
    load_words.delete();
    checkOutput("load_writes", 64'(wrq.size()), 64'd3);
    checkOutput("load_w0", 64'(wrq[0]), 64'({6'd0, 32'h3C010001}));
    checkOutput("load_w1", 64'(wrq[1]), 64'({6'd1, 32'h3C030003}));
    checkOutput("load_w2", 64'(wrq[2]), 64'({6'd2, 32'h00000000}));
    checkOutput("load_ack", 64'(txq[0]), 64'h52);

    // Step mode: exactly one free-running cycle.
    stall_low = 0;
    doCommand(8'h11, 8'h00, 1'b0);
    doCommand(8'h0D, 8'h00, 1'b0);
    doCommand(8'h0A, 8'h00, 1'b0);
    checkOutput("step_low_cycles", 64'(stall_low), 64'd1);
    doCommand(8'h0B, 8'h00, 1'b0);

    // Directed ID/EX dump.
    i_id_ex = 129'h1_0123456789ABCDEF_FEDCBA9876543210;
    doCommand(8'h03, 8'h00, 1'b0);
    checkOutput("idex_count", 64'(txq.size()), 64'd18);
    for (int k = 0; k < 17; k++) checkOutput("idex_byte", 64'(txq[k]), 64'(idex_exp[k]));

    // Continuous run then halt.
    doCommand(8'h08, 8'h00, 1'b0);
    doCommand(8'h0D, 8'h00, 1'b0);
    checkOutput("run_stall", 64'(o_stall), 64'd0);
    doCommand(8'h0B, 8'h00, 1'b0);
    checkOutput("halt_stall", 64'(o_stall), 64'd1);

    // Randomized command mix.
    for (int it = 0; it < 40; it++) begin
      c = cmds[$urandom_range(0, 12)];
      cnt = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) cnt = ($urandom_range(0, 1) == 0) ? 8'd64 : 8'd200;
      for (int r = 0; r < 32; r++) regs[r] = $urandom;
      randomizeLatches();
      doCommand(c, cnt, c == 8'h01);
    end

    // Reset in the middle of a load.
    doCommand(8'h08, 8'h00, 1'b0);
    txq.delete();
    wrq.delete();
    applyStimulus(8'h07);
    m_run       = 1'b0;
    exp_cpu_rst = 1;
    applyStimulus(8'h02);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    i_rst       = 1'b1;
    m_run       = 1'b0;
    m_step_mode = 1'b0;
    m_step_now  = 1'b0;
    exp_cpu_rst = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    checkOutput("abort_writes", 64'(wrq.size()), 64'd0);
    checkOutput("abort_tx", 64'(txq.size()), 64'd0);
    checkOutput("abort_stall", 64'(o_stall), 64'd1);
    doCommand(8'h08, 8'h00, 1'b0);
    checkOutput("after_abort_ack", 64'(txq.size()), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
